// File: rtl/mmse_pkg.sv
// Shared types and saturating fixed-point helpers for the 4x4 Gauss-Jordan MMSE solver.
package mmse_pkg;
  localparam int FRAC_DEFAULT = 16;

  typedef logic signed [31:0] fxp_t;

  typedef enum logic [2:0] {IDLE, DIV, NORM, ELIM, DONE} state_t;

  localparam logic signed [63:0] FX_MAX = 64'sd2147483647;
  localparam logic signed [63:0] FX_MIN = -64'sd2147483648;

  // Full 64-bit product, floor shift by frac, clamp to the 32-bit range.
  function automatic fxp_t fxmul(input fxp_t a, input fxp_t b, input int frac);
    logic signed [63:0] ae;
    logic signed [63:0] be;
    logic signed [63:0] p;
    ae = {{32{a[31]}}, a};
    be = {{32{b[31]}}, b};
    p  = ae * be;
    p  = p >>> frac;
    if (p > FX_MAX) p = FX_MAX;
    else if (p < FX_MIN) p = FX_MIN;
    return p[31:0];
  endfunction

  function automatic fxp_t sat_sub(input fxp_t a, input fxp_t b);
    logic signed [32:0] d;
    d = {a[31], a} - {b[31], b};
    if (d[32] != d[31]) return d[32] ? 32'sh80000000 : 32'sh7fffffff;
    return d[31:0];
  endfunction
endpackage

// File: rtl/mmse_solver_recip.sv
// Sequential restoring divider producing 2^(2*FRAC)/divisor, sign-fixed and saturated.
module fxp_recip
  import mmse_pkg::*;
#(
  parameter int FRAC       = FRAC_DEFAULT,
  parameter int DIV_CYCLES = 33
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  fxp_t divisor,
  output logic done,
  output fxp_t quotient
);
  localparam int QW = 2 * FRAC;
  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [32:0]    dvs_reg;
  logic [32:0]    rem_reg;
  logic [QW-1:0]  quo_reg;
  logic           ovf_reg;
  logic           neg_reg;
  logic           busy_reg;
  logic [CW-1:0]  cnt_reg;

  logic [32:0] div_ext;
  logic [32:0] mag;
  logic [32:0] dvs_cur;
  logic [32:0] rem_in;
  logic [33:0] trial;
  logic        q_bit;
  logic [32:0] rem_new;
  logic [63:0] qmag;

  // The dividend is a lone 1 at bit QW: that bit only divides when |divisor| == 1,
  // so the remainder is seeded directly and the first real bit is resolved on start.
  always_comb begin
    div_ext = {divisor[31], divisor};
    mag     = div_ext[32] ? (~div_ext + 33'd1) : div_ext;
    dvs_cur = start ? mag : dvs_reg;
    rem_in  = start ? ((mag == 33'd1) ? 33'd0 : 33'd1) : rem_reg;
    trial   = {rem_in, 1'b0};
    q_bit   = (trial >= {1'b0, dvs_cur});
    rem_new = q_bit ? 33'(trial - {1'b0, dvs_cur}) : trial[32:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvs_reg  <= '0;
      rem_reg  <= '0;
      quo_reg  <= '0;
      ovf_reg  <= 1'b0;
      neg_reg  <= 1'b0;
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (start) begin
      dvs_reg  <= mag;
      rem_reg  <= rem_new;
      quo_reg  <= QW'(q_bit);
      ovf_reg  <= (mag == 33'd1);
      neg_reg  <= divisor[31];
      busy_reg <= 1'b1;
      cnt_reg  <= CW'(1);
    end else if (busy_reg) begin
      if (cnt_reg < CW'(QW)) begin
        rem_reg <= rem_new;
        quo_reg <= {quo_reg[QW-2:0], q_bit};
      end
      if (done) busy_reg <= 1'b0;
      else cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign done = busy_reg && (cnt_reg == CW'(DIV_CYCLES - 1));

  always_comb begin
    qmag = 64'({ovf_reg, quo_reg});
    if (neg_reg) quotient = (qmag > 64'h80000000) ? 32'sh80000000 : ~qmag[31:0] + 32'd1;
    else quotient = (qmag > 64'h7fffffff) ? 32'sh7fffffff : qmag[31:0];
  end
endmodule

// File: rtl/mmse_solver.sv
// 4x4 fixed-point Gauss-Jordan solver (no pivoting) for the MMSE equaliser: A*x = b.
module mmse_solver
  import mmse_pkg::*;
#(
  parameter int FRAC       = FRAC_DEFAULT,
  parameter int DIV_CYCLES = 33,
  parameter int PIVOT_MIN  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:3][0:3][31:0]  matrix_A,
  input  logic [0:3][31:0]       vector_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:3][31:0]       x_hat,
  output logic                   singular
);
  state_t      state_reg, state_next;
  fxp_t        m_reg [0:3][0:4];
  logic [1:0]  k_reg;
  logic [1:0]  row_reg;
  logic [2:0]  col_reg;
  logic        div_first_reg;
  logic        abort_reg;
  fxp_t        recip_reg;
  fxp_t        factor_reg;
  fxp_t        x_reg [0:3];
  logic        singular_reg;

  logic              recip_start;
  logic              recip_done;
  fxp_t              recip_q;
  fxp_t              pivot;
  logic signed [32:0] pivot_ext;
  logic signed [32:0] pivot_mag;
  logic              pivot_small;
  fxp_t              factor_cur;
  fxp_t              mul_a;
  fxp_t              mul_b;
  fxp_t              mul_p;
  fxp_t              elim_val;
  logic [1:0]        first_row;
  logic [1:0]        last_row;
  logic [1:0]        row_inc;
  logic [1:0]        next_row;

  fxp_recip #(.FRAC(FRAC), .DIV_CYCLES(DIV_CYCLES)) u_recip (
    .clk      (clk),
    .reset    (reset),
    .start    (recip_start),
    .divisor  (pivot),
    .done     (recip_done),
    .quotient (recip_q)
  );

  // Single shared multiplier: NORM scales the pivot row, ELIM forms factor * pivot-row.
  always_comb begin
    pivot       = m_reg[k_reg][k_reg];
    pivot_ext   = {pivot[31], pivot};
    pivot_mag   = pivot_ext[32] ? -pivot_ext : pivot_ext;
    pivot_small = (pivot_mag < 33'(PIVOT_MIN));
    first_row   = (k_reg == 2'd0) ? 2'd1 : 2'd0;
    last_row    = (k_reg == 2'd3) ? 2'd2 : 2'd3;
    row_inc     = row_reg + 2'd1;
    next_row    = (row_inc == k_reg) ? row_inc + 2'd1 : row_inc;
    factor_cur  = (col_reg == 3'd0) ? m_reg[row_reg][k_reg] : factor_reg;
    if (state_reg == NORM) begin
      mul_a = m_reg[k_reg][col_reg];
      mul_b = recip_reg;
    end else begin
      mul_a = factor_cur;
      mul_b = m_reg[k_reg][col_reg];
    end
    mul_p    = fxmul(mul_a, mul_b, FRAC);
    elim_val = sat_sub(m_reg[row_reg][col_reg], mul_p);
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    recip_start = 1'b0;
    unique case (state_reg)
      IDLE: if (in_valid) state_next = DIV;
      DIV: begin
        // A small pivot spends one extra DIV cycle so the abort flag is registered first.
        if (abort_reg) state_next = DONE;
        else if (div_first_reg) recip_start = !pivot_small;
        else if (recip_done) state_next = NORM;
      end
      NORM: if (col_reg == 3'd4) state_next = ELIM;
      ELIM: begin
        if (col_reg == 3'd4 && row_reg == last_row)
          state_next = (k_reg == 2'd3) ? DONE : DIV;
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 5; c++) m_reg[r][c] <= '0;
        x_reg[r] <= '0;
      end
      k_reg         <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      div_first_reg <= 1'b0;
      abort_reg     <= 1'b0;
      recip_reg     <= '0;
      factor_reg    <= '0;
      singular_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: if (in_valid) begin
          for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) m_reg[r][c] <= matrix_A[r][c];
            m_reg[r][4] <= vector_b[r];
          end
          k_reg         <= '0;
          col_reg       <= '0;
          div_first_reg <= 1'b1;
          abort_reg     <= 1'b0;
        end
        DIV: begin
          div_first_reg <= 1'b0;
          if (div_first_reg && pivot_small) begin
            abort_reg    <= 1'b1;
            singular_reg <= 1'b1;
            for (int j = 0; j < 4; j++) x_reg[j] <= '0;
          end else if (!div_first_reg && !abort_reg && recip_done) begin
            recip_reg <= recip_q;
            col_reg   <= '0;
          end
        end
        NORM: begin
          m_reg[k_reg][col_reg] <= mul_p;
          if (col_reg == 3'd4) begin
            col_reg <= '0;
            row_reg <= first_row;
          end else begin
            col_reg <= col_reg + 3'd1;
          end
        end
        ELIM: begin
          m_reg[row_reg][col_reg] <= elim_val;
          if (col_reg == 3'd0) factor_reg <= m_reg[row_reg][k_reg];
          if (col_reg == 3'd4) begin
            col_reg <= '0;
            if (row_reg == last_row) begin
              if (k_reg == 2'd3) begin
                for (int j = 0; j < 4; j++)
                  x_reg[j] <= (2'(j) == row_reg) ? elim_val : m_reg[j][4];
                singular_reg <= 1'b0;
              end else begin
                k_reg         <= k_reg + 2'd1;
                div_first_reg <= 1'b1;
              end
            end else begin
              row_reg <= next_row;
            end
          end else begin
            col_reg <= col_reg + 3'd1;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign singular  = singular_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_xout
    assign x_hat[gi] = x_reg[gi];
  end
endmodule
